// File: rtl/rom_download_router.sv
// ----------------------------------------------------------------------------
// rom_download_router
//
// Sits between the HPS ioctl download stream and the Slap Fight game core.
// Every byte of the index-0 ROM download is decoded into one of six ROM
// regions and re-issued one cycle later as a one-hot write strobe carrying a
// region-local address. Alongside the routing it counts accepted bytes, sums
// a 16-bit checksum, flags bytes addressed past the end of the image, and
// keeps the game core in reset until a complete image has been loaded and a
// short release delay has elapsed.
//
// Ports
//   clk_sys       in   system clock
//   RESET_n       in   asynchronous active-low reset
//   dn_download   in   ioctl download active
//   dn_index      in   ioctl index (only index 0 is the ROM image)
//   dn_wr         in   ioctl byte-valid strobe
//   dn_addr[24:0] in   byte address within the image
//   dn_data[7:0]  in   byte data
//   rgn_wr[5:0]   out  one-hot write strobe, one bit per ROM region
//   rgn_addr[17:0]out  region-local address of the strobed byte
//   rgn_data[7:0] out  data of the strobed byte
//   loading       out  a ROM download is in progress
//   load_ok       out  last download was complete and had no overflow
//   overflow      out  sticky: a byte beyond the image end was seen
//   byte_count    out  accepted-byte counter, saturating
//   checksum[15:0]out  modulo-2^16 sum of accepted bytes
//   core_reset_n  out  active-low reset for the game core
// ----------------------------------------------------------------------------
module rom_download_router #(
   parameter logic [17:0] R0_END         = 18'h08000,
   parameter logic [17:0] R1_END         = 18'h10000,
   parameter logic [17:0] R2_END         = 18'h12000,
   parameter logic [17:0] R3_END         = 18'h14000,
   parameter logic [17:0] R4_END         = 18'h24000,
   parameter logic [17:0] R5_END         = 18'h34000,
   parameter int          RELEASE_CYCLES = 16
) (
   input  logic        clk_sys,
   input  logic        RESET_n,
   input  logic        dn_download,
   input  logic [7:0]  dn_index,
   input  logic        dn_wr,
   input  logic [24:0] dn_addr,
   input  logic [7:0]  dn_data,
   output logic [5:0]  rgn_wr,
   output logic [17:0] rgn_addr,
   output logic [7:0]  rgn_data,
   output logic        loading,
   output logic        load_ok,
   output logic        overflow,
   output logic [17:0] byte_count,
   output logic [15:0] checksum,
   output logic        core_reset_n
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DONE
   } state_t;

   // The release counter only needs to reach RELEASE_CYCLES and then park.
   localparam int              REL_W      = $clog2(RELEASE_CYCLES + 1) + 1;
   localparam logic [REL_W-1:0] REL_TARGET = REL_W'(RELEASE_CYCLES);
   localparam logic [17:0]     COUNT_MAX  = 18'h3FFFF;

   state_t           state;
   logic [REL_W-1:0] rel_cnt;

   logic             rom_dl;
   logic             rom_dl_q;
   logic             dl_rise;
   logic             dl_fall;

   logic [5:0]       region_hit;
   logic [17:0]      region_base;
   logic             in_range;
   logic [17:0]      region_offset;

   logic             accept_wr;
   logic             take_byte;
   logic             drop_byte;
   logic [17:0]      count_next;
   logic [15:0]      sum_next;
   logic             ovf_next;

   // Only index 0 is the ROM image; other ioctl indices (config, NVRAM, ...)
   // pass by without touching this block.
   assign rom_dl  = dn_download & (dn_index == 8'd0);
   assign dl_rise = rom_dl & ~rom_dl_q;
   assign dl_fall = ~rom_dl & rom_dl_q;

   // Registered copy of the qualified download flag for edge detection.
   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         rom_dl_q <= 1'b0;
      end else begin
         rom_dl_q <= rom_dl;
      end
   end

   // Address decode. The comparisons use all 25 address bits so that an
   // address with high bits set can never alias back into a low region.
   // The region base is kept alongside so the local offset can be formed
   // in 18 bits: inside a region the difference always fits.
   always_comb begin
      region_hit  = 6'b000000;
      region_base = 18'h00000;
      if (dn_addr < {7'd0, R0_END}) begin
         region_hit  = 6'b000001;
         region_base = 18'h00000;
      end else if (dn_addr < {7'd0, R1_END}) begin
         region_hit  = 6'b000010;
         region_base = R0_END;
      end else if (dn_addr < {7'd0, R2_END}) begin
         region_hit  = 6'b000100;
         region_base = R1_END;
      end else if (dn_addr < {7'd0, R3_END}) begin
         region_hit  = 6'b001000;
         region_base = R2_END;
      end else if (dn_addr < {7'd0, R4_END}) begin
         region_hit  = 6'b010000;
         region_base = R3_END;
      end else if (dn_addr < {7'd0, R5_END}) begin
         region_hit  = 6'b100000;
         region_base = R4_END;
      end
   end

   assign in_range      = |region_hit;
   assign region_offset = dn_addr[17:0] - region_base;

   // A byte is only considered while the FSM is already in LOAD; a write in
   // the same cycle as the rising edge is still outside the load window.
   assign accept_wr = (state == ST_LOAD) & dn_wr & rom_dl;
   assign take_byte = accept_wr & in_range;
   assign drop_byte = accept_wr & ~in_range;

   // Next-state view of the counters, so that the completion check on the
   // falling edge sees any byte accepted in that same cycle.
   always_comb begin
      count_next = byte_count;
      sum_next   = checksum;
      if (take_byte) begin
         if (byte_count != COUNT_MAX) begin
            count_next = byte_count + 18'd1;
         end
         sum_next = checksum + {8'd0, dn_data};
      end
   end

   assign ovf_next = overflow | drop_byte;

   // Write-strobe pipeline: one-cycle strobe, address and data held until
   // the next accepted byte replaces them.
   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         rgn_wr   <= 6'b000000;
         rgn_addr <= 18'h00000;
         rgn_data <= 8'h00;
      end else begin
         rgn_wr <= take_byte ? region_hit : 6'b000000;
         if (take_byte) begin
            rgn_addr <= region_offset;
            rgn_data <= dn_data;
         end
      end
   end

   // Download FSM with its counters and registered status outputs.
   // A rising edge from IDLE or DONE starts a fresh load and re-asserts the
   // core reset; a falling edge in LOAD latches the completion verdict; DONE
   // counts off the release delay and frees the core only for a good image.
   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         state        <= ST_IDLE;
         rel_cnt      <= '0;
         loading      <= 1'b0;
         load_ok      <= 1'b0;
         overflow     <= 1'b0;
         byte_count   <= 18'h00000;
         checksum     <= 16'h0000;
         core_reset_n <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (dl_rise) begin
                  state        <= ST_LOAD;
                  loading      <= 1'b1;
                  load_ok      <= 1'b0;
                  overflow     <= 1'b0;
                  byte_count   <= 18'h00000;
                  checksum     <= 16'h0000;
                  core_reset_n <= 1'b0;
                  rel_cnt      <= '0;
               end
            end

            ST_LOAD: begin
               byte_count <= count_next;
               checksum   <= sum_next;
               overflow   <= ovf_next;
               if (dl_fall) begin
                  state   <= ST_DONE;
                  loading <= 1'b0;
                  load_ok <= (count_next == R5_END) & ~ovf_next;
                  rel_cnt <= '0;
               end
            end

            ST_DONE: begin
               if (dl_rise) begin
                  state        <= ST_LOAD;
                  loading      <= 1'b1;
                  load_ok      <= 1'b0;
                  overflow     <= 1'b0;
                  byte_count   <= 18'h00000;
                  checksum     <= 16'h0000;
                  core_reset_n <= 1'b0;
                  rel_cnt      <= '0;
               end else if (rel_cnt == REL_TARGET) begin
                  if (load_ok) begin
                     core_reset_n <= 1'b1;
                  end
               end else begin
                  rel_cnt <= rel_cnt + 1'b1;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_download_router.sv
// ----------------------------------------------------------------------------
// tb_rom_download_router
//
// Randomised and directed stimulus for rom_download_router, checked against a
// behavioural model of the download rules (region table lookup, integer
// counters, a release countdown). The region map is scaled down by 256 so a
// whole image streams through in a few hundred cycles while keeping the same
// relative layout.
// ----------------------------------------------------------------------------
module tb_rom_download_router;

   localparam logic [17:0] P_R0  = 18'h00080;
   localparam logic [17:0] P_R1  = 18'h00100;
   localparam logic [17:0] P_R2  = 18'h00120;
   localparam logic [17:0] P_R3  = 18'h00140;
   localparam logic [17:0] P_R4  = 18'h00240;
   localparam logic [17:0] P_R5  = 18'h00340;
   localparam int          P_REL = 16;

   logic        clk_sys = 1'b0;
   logic        RESET_n;
   logic        dn_download;
   logic [7:0]  dn_index;
   logic        dn_wr;
   logic [24:0] dn_addr;
   logic [7:0]  dn_data;
   logic [5:0]  rgn_wr;
   logic [17:0] rgn_addr;
   logic [7:0]  rgn_data;
   logic        loading;
   logic        load_ok;
   logic        overflow;
   logic [17:0] byte_count;
   logic [15:0] checksum;
   logic        core_reset_n;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int          bounds [6];
   bit          m_active;
   bit          m_prev_dl;
   bit          m_ovf;
   bit          m_ok;
   bit          m_core;
   int          m_count;
   int          m_sum;
   int          m_done;
   logic [5:0]  m_wr;
   logic [17:0] m_addr;
   logic [7:0]  m_data;
   int          cycle_mismatch;
   int          obs_strobes [6];

   rom_download_router #(
      .R0_END         (P_R0),
      .R1_END         (P_R1),
      .R2_END         (P_R2),
      .R3_END         (P_R3),
      .R4_END         (P_R4),
      .R5_END         (P_R5),
      .RELEASE_CYCLES (P_REL)
   ) dut (
      .clk_sys      (clk_sys),
      .RESET_n      (RESET_n),
      .dn_download  (dn_download),
      .dn_index     (dn_index),
      .dn_wr        (dn_wr),
      .dn_addr      (dn_addr),
      .dn_data      (dn_data),
      .rgn_wr       (rgn_wr),
      .rgn_addr     (rgn_addr),
      .rgn_data     (rgn_data),
      .loading      (loading),
      .load_ok      (load_ok),
      .overflow     (overflow),
      .byte_count   (byte_count),
      .checksum     (checksum),
      .core_reset_n (core_reset_n)
   );

   always #5 clk_sys = ~clk_sys;

   // Hang guard: report and stop if the bench ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic int region_lo(input int k);
      return (k == 0) ? 0 : bounds[k-1];
   endfunction

   function automatic int region_of(input logic [24:0] a);
      int ai;
      ai = int'(a);
      for (int k = 0; k < 6; k++) begin
         if (ai >= region_lo(k) && ai < bounds[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_active  = 1'b0;
      m_prev_dl = 1'b0;
      m_ovf     = 1'b0;
      m_ok      = 1'b0;
      m_core    = 1'b0;
      m_count   = 0;
      m_sum     = 0;
      m_done    = -1;
      m_wr      = '0;
      m_addr    = '0;
      m_data    = '0;
   endtask

   // Expected register contents after one clock edge with the given inputs.
   task automatic model_step(input bit dl, input logic [7:0] idx, input bit wr,
                             input logic [24:0] addr, input logic [7:0] data);
      bit rom;
      int r;
      rom  = dl && (idx == 8'd0);
      m_wr = '0;
      if (m_active && wr && rom) begin
         r = region_of(addr);
         if (r >= 0) begin
            m_wr   = 6'(1 << r);
            m_addr = 18'(int'(addr) - region_lo(r));
            m_data = data;
            if (m_count < 262143) m_count++;
            m_sum = (m_sum + int'(data)) % 65536;
         end else begin
            m_ovf = 1'b1;
         end
      end
      if (rom && !m_prev_dl) begin
         m_active = 1'b1;
         m_count  = 0;
         m_sum    = 0;
         m_ovf    = 1'b0;
         m_ok     = 1'b0;
         m_core   = 1'b0;
         m_done   = -1;
      end else if (!rom && m_prev_dl && m_active) begin
         m_active = 1'b0;
         m_ok     = (m_count == int'(P_R5)) && !m_ovf;
         m_done   = 0;
      end else if (m_done >= 0) begin
         m_done++;
         if (m_done >= P_REL + 1 && m_ok) m_core = 1'b1;
      end
      m_prev_dl = rom;
   endtask

   task automatic applyStimulus(input bit dl, input logic [7:0] idx, input bit wr,
                                input logic [24:0] addr, input logic [7:0] data);
      @(negedge clk_sys);
      dn_download = dl;
      dn_index    = idx;
      dn_wr       = wr;
      dn_addr     = addr;
      dn_data     = data;
      @(posedge clk_sys);
      #1;
      model_step(dl, idx, wr, addr, data);
      if (rgn_wr !== m_wr || rgn_addr !== m_addr || rgn_data !== m_data ||
          loading !== m_active || load_ok !== m_ok || overflow !== m_ovf ||
          byte_count !== m_count[17:0] || checksum !== m_sum[15:0] ||
          core_reset_n !== m_core) begin
         cycle_mismatch++;
      end
      for (int k = 0; k < 6; k++) begin
         if (rgn_wr[k] === 1'b1) obs_strobes[k]++;
      end
   endtask

   // Idle cycles after a fall; returns how many edges it took for the core
   // reset to release, or -1 if it never did within the window.
   task automatic wait_release(output int latency);
      latency = -1;
      for (int i = 1; i <= 40; i++) begin
         applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
         if (core_reset_n === 1'b1 && latency < 0) latency = i;
      end
   endtask

   task automatic full_download(input string tag);
      int   latency;
      int   n;
      int   exp_sum;
      logic [31:0] lat_obs;
      for (int k = 0; k < 6; k++) obs_strobes[k] = 0;
      applyStimulus(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
      for (int a = 0; a < int'(P_R5); a++) begin
         applyStimulus(1'b1, 8'd0, 1'b1, 25'(a), 8'(a));
         if (a == int'(P_R2)) begin
            checkOutput({tag, "_r3_first_wr"}, rgn_wr, 6'b001000);
            checkOutput({tag, "_r3_first_addr"}, rgn_addr, 0);
         end
      end
      applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("%s_strobes_r%0d", tag, k), obs_strobes[k], bounds[k] - region_lo(k));
      end
      n       = int'(P_R5);
      exp_sum = ((n / 256) * 32640 + ((n % 256) * ((n % 256) - 1)) / 2) % 65536;
      checkOutput({tag, "_load_ok"}, load_ok, 1);
      checkOutput({tag, "_byte_count"}, byte_count, n);
      checkOutput({tag, "_checksum"}, checksum, exp_sum);
      checkOutput({tag, "_loading_after_fall"}, loading, 0);
      wait_release(latency);
      lat_obs = latency;
      checkOutput({tag, "_release_latency"}, lat_obs, P_REL + 1);
   endtask

   initial begin
      int latency;
      int strobe_cycles;
      logic [24:0] ra;

      bounds[0] = int'(P_R0);
      bounds[1] = int'(P_R1);
      bounds[2] = int'(P_R2);
      bounds[3] = int'(P_R3);
      bounds[4] = int'(P_R4);
      bounds[5] = int'(P_R5);
      cycle_mismatch = 0;
      for (int k = 0; k < 6; k++) obs_strobes[k] = 0;

      RESET_n     = 1'b0;
      dn_download = 1'b0;
      dn_index    = 8'd0;
      dn_wr       = 1'b0;
      dn_addr     = 25'd0;
      dn_data     = 8'd0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk_sys);
      #1;
      checkOutput("reset_rgn_wr", rgn_wr, 0);
      checkOutput("reset_rgn_addr", rgn_addr, 0);
      checkOutput("reset_rgn_data", rgn_data, 0);
      checkOutput("reset_loading", loading, 0);
      checkOutput("reset_load_ok", load_ok, 0);
      checkOutput("reset_overflow", overflow, 0);
      checkOutput("reset_byte_count", byte_count, 0);
      checkOutput("reset_checksum", checksum, 0);
      checkOutput("reset_core_reset_n", core_reset_n, 0);
      @(negedge clk_sys);
      RESET_n = 1'b1;

      // Non-zero index downloads are invisible to the router
      for (int k = 0; k < 6; k++) obs_strobes[k] = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 8'd1, i[0], 25'(i * 17), 8'hA5);
      end
      applyStimulus(1'b0, 8'd1, 1'b0, 25'd0, 8'd0);
      checkOutput("index_byte_count", byte_count, 0);
      checkOutput("index_loading", loading, 0);
      checkOutput("index_strobes", obs_strobes[0] + obs_strobes[1] + obs_strobes[2] +
                  obs_strobes[3] + obs_strobes[4] + obs_strobes[5], 0);

      // Whole image in address order
      full_download("full");

      // Region boundaries and the overflow region
      applyStimulus(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
      checkOutput("bound_loading", loading, 1);
      checkOutput("bound_core_held", core_reset_n, 0);
      applyStimulus(1'b1, 8'd0, 1'b1, 25'(P_R0) - 25'd1, 8'h11);
      checkOutput("bound_r0_last", rgn_wr, 6'b000001);
      checkOutput("bound_r0_last_addr", rgn_addr, P_R0 - 18'd1);
      applyStimulus(1'b1, 8'd0, 1'b1, 25'(P_R0), 8'h22);
      checkOutput("bound_r1_first", rgn_wr, 6'b000010);
      checkOutput("bound_r1_first_addr", rgn_addr, 0);
      applyStimulus(1'b1, 8'd0, 1'b1, 25'(P_R5) - 25'd1, 8'h33);
      checkOutput("bound_r5_last", rgn_wr, 6'b100000);
      checkOutput("bound_r5_last_data", rgn_data, 8'h33);
      checkOutput("bound_no_overflow_yet", overflow, 0);
      applyStimulus(1'b1, 8'd0, 1'b1, 25'(P_R5), 8'h44);
      checkOutput("bound_past_end", rgn_wr, 0);
      checkOutput("bound_overflow", overflow, 1);
      applyStimulus(1'b1, 8'd0, 1'b1, 25'h0040010, 8'h55);
      checkOutput("bound_high_bits", rgn_wr, 0);
      checkOutput("bound_count", byte_count, 3);
      checkOutput("bound_checksum", checksum, 16'h0066);
      applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
      checkOutput("bound_load_ok", load_ok, 0);
      wait_release(latency);
      checkOutput("bound_core_held_after", core_reset_n, 0);

      // Short image: random in-range bytes, then an early fall
      applyStimulus(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1, 8'd0, 1'b1, 25'($urandom_range(0, int'(P_R5) - 1)), 8'($urandom));
      end
      applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
      checkOutput("short_count", byte_count, 100);
      checkOutput("short_load_ok", load_ok, 0);
      wait_release(latency);
      checkOutput("short_core_held", core_reset_n, 0);

      // Back-to-back writes then a random mix including out-of-range bytes
      applyStimulus(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
      strobe_cycles = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'd0, 1'b1, 25'($urandom_range(0, int'(P_R5) - 1)), 8'($urandom));
         if ($countones(rgn_wr) == 1 && rgn_wr === m_wr) strobe_cycles++;
      end
      applyStimulus(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
      checkOutput("b2b_strobe_cycles", strobe_cycles, 8);
      checkOutput("b2b_strobe_drops", rgn_wr, 0);
      checkOutput("b2b_count", byte_count, 8);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0)
            ra = 25'($urandom_range(int'(P_R5), 25'h1FFFFFF));
         else
            ra = 25'($urandom_range(0, int'(P_R5) - 1));
         applyStimulus(1'b1, 8'd0, 1'($urandom), ra, 8'($urandom));
      end
      applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
      wait_release(latency);
      checkOutput("random_cycle_mismatches", cycle_mismatch, 0);

      // Asynchronous reset in the middle of a load
      applyStimulus(1'b1, 8'd0, 1'b0, 25'd0, 8'd0);
      for (int a = 0; a < 500; a++) begin
         applyStimulus(1'b1, 8'd0, 1'b1, 25'(a), 8'(a + 3));
      end
      checkOutput("areset_pre_count", byte_count, 500);
      @(posedge clk_sys);
      #3;
      RESET_n     = 1'b0;
      dn_download = 1'b0;
      dn_wr       = 1'b0;
      #1;
      checkOutput("areset_rgn_wr", rgn_wr, 0);
      checkOutput("areset_rgn_addr", rgn_addr, 0);
      checkOutput("areset_rgn_data", rgn_data, 0);
      checkOutput("areset_loading", loading, 0);
      checkOutput("areset_byte_count", byte_count, 0);
      checkOutput("areset_checksum", checksum, 0);
      checkOutput("areset_overflow", overflow, 0);
      checkOutput("areset_load_ok", load_ok, 0);
      checkOutput("areset_core_reset_n", core_reset_n, 0);
      model_reset();
      repeat (2) @(posedge clk_sys);
      @(negedge clk_sys);
      RESET_n = 1'b1;
      applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 8'd0);
      checkOutput("areset_idle_loading", loading, 0);
      full_download("reload");

      checkOutput("total_cycle_mismatches", cycle_mismatch, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
